seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_hex_dec.sv | 20 ++
 rtl/seg7_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and constants for the 4-digit 7-segment scanner:
//               scan state encoding, display word layout, hex segment table
//               and segment bit positions (a..g on bits 0..6).
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  // One display word: four hex digits plus a decimal point per digit
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
  } disp_word_t;

  // Segment bit positions within seg_out
  localparam int unsigned c_seg_a = 0;
  localparam int unsigned c_seg_b = 1;
  localparam int unsigned c_seg_c = 2;
  localparam int unsigned c_seg_d = 3;
  localparam int unsigned c_seg_e = 4;
  localparam int unsigned c_seg_f = 5;
  localparam int unsigned c_seg_g = 6;

  // Hex-to-segment table, entry N lights the glyph for digit N (F is leftmost)
  localparam logic [15:0][6:0] c_hex_seg = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_dec
// Description : Combinational hex digit to active-high 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the selected digit
  always_comb begin
    seg = c_hex_seg[hex];
  end

endmodule : seg7_hex_dec
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed 4-digit 7-segment scan controller with a
//               valid/ready word input and a one-deep shadow register that is
//               promoted to the displayed word at frame boundaries.
//               Optional blinking is enabled by defining SEG7_BLINK_EN, which
//               adds the blink_en port and an 8-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL     = 1000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_SH  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_digits,
  input  logic [3:0]  req_dp,
`ifdef SEG7_BLINK_EN
  input  logic        blink_en,
`endif
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  dig_sel,
  output logic        frame_done
);

  localparam logic [15:0] c_dwell_last = 16'(DWELL - 1);
  localparam logic [15:0] c_blank_last = 16'(BLANK_CYC - 1);
  // With no blanking, every digit starts directly in ON
  localparam state_t      c_digit_start = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;

  // Elaboration-time guard on the legal parameter ranges
  if (DWELL < 1 || DWELL > 65535 || BLANK_CYC < 0 || BLANK_CYC > 255 ||
      BLINK_SH < 0 || BLINK_SH > 7) begin : g_param_check
    $error("seg7_scan_ctrl: parameter out of legal range");
  end

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [15:0] r_cnt;
  disp_word_t  r_active;
  disp_word_t  r_shadow;
  logic        r_shadow_full;
`ifdef SEG7_BLINK_EN
  logic [7:0]  r_frame_cnt;
`endif

  logic        w_accept;
  logic        w_lit;
  logic        w_last_on;
  logic        w_blank_seg;
  logic [3:0]  w_cur_hex;
  logic [6:0]  w_cur_seg;
  disp_word_t  w_req_word;

  assign w_req_word = '{digits: req_digits, dp: req_dp};
  assign w_accept   = req_valid && req_ready;
  assign w_lit      = (r_state == ST_ON);
  assign w_last_on  = w_lit && (r_cnt == c_dwell_last);
  assign w_cur_hex  = r_active.digits[{r_idx, 2'b00} +: 4];

`ifdef SEG7_BLINK_EN
  assign w_blank_seg = blink_en && r_frame_cnt[BLINK_SH];
`else
  assign w_blank_seg = 1'b0;
`endif

  seg7_hex_dec u_hex_dec (
    .hex (w_cur_hex),
    .seg (w_cur_seg)
  );

  // Scan FSM: state, digit index, dwell/blank counter and word registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= 2'd0;
      r_cnt         <= 16'd0;
      r_active      <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
`ifdef SEG7_BLINK_EN
      r_frame_cnt   <= 8'd0;
`endif
    end else if (!ena) begin
      // Active word is kept; a pending shadow word is discarded
      r_state       <= ST_IDLE;
      r_idx         <= 2'd0;
      r_cnt         <= 16'd0;
      r_shadow_full <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_active <= w_req_word;
            r_state  <= c_digit_start;
            r_idx    <= 2'd0;
            r_cnt    <= 16'd0;
          end
        end
        ST_BLANK: begin
          if (r_cnt == c_blank_last) begin
            r_state <= ST_ON;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_ON: begin
          if (r_cnt == c_dwell_last) begin
            r_state <= c_digit_start;
            r_cnt   <= 16'd0;
            r_idx   <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              if (r_shadow_full) begin
                r_active <= r_shadow;
              end
              r_shadow_full <= 1'b0;
`ifdef SEG7_BLINK_EN
              r_frame_cnt   <= r_frame_cnt + 8'd1;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // A word taken while scanning waits in the shadow for the frame end;
      // this overrides the frame-end clear when both land on the same edge.
      if (w_accept && (r_state != ST_IDLE)) begin
        r_shadow      <= w_req_word;
        r_shadow_full <= 1'b1;
      end
    end
  end

  // Display outputs and handshake decoded from registered state
  always_comb begin
    req_ready  = rst_n && ena && ((r_state == ST_IDLE) || !r_shadow_full);
    dig_sel    = w_lit ? (4'b0001 << r_idx) : 4'b0000;
    seg_out    = (w_lit && !w_blank_seg) ? w_cur_seg : 7'h00;
    dp_out     = w_lit && !w_blank_seg && r_active.dp[r_idx];
    frame_done = w_last_on && (r_idx == 2'd3);
  end

endmodule : seg7_scan_ctrl
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Directed, self-checking bench for seg7_scan_ctrl with
//               DWELL=4, BLANK_CYC=1 (20-cycle frame). Accepted words are
//               queued as expected display words and consumed frame by frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int TB_DWELL    = 4;
  localparam int TB_BLANK    = 1;
  localparam int TB_BLINK_SH = 0;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
  } tw_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_digits;
  logic [3:0]  req_dp;
  logic        blink_en;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_done;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_acc    = 0;
  int  m_idx    = 0;
  int  m_frame  = 0;
  bit  m_idle   = 1'b1;
  tw_t sb_words[$];
  tw_t pend_offers[$];
  tw_t cur_offer;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DWELL     (TB_DWELL),
    .BLANK_CYC (TB_BLANK),
    .BLINK_SH  (TB_BLINK_SH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_digits (req_digits),
    .req_dp     (req_dp),
`ifdef SEG7_BLINK_EN
    .blink_en   (blink_en),
`endif
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  function automatic logic exp_ready();
    return rst_n && ena && (m_idle || (sb_words.size() <= 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer_word(input logic [15:0] d, input logic [3:0] p);
    cur_offer  = '{digits: d, dp: p};
    req_digits = d;
    req_dp     = p;
    req_valid  = 1'b1;
  endtask

  // One clock; an accept seen before the edge is pushed to the scoreboard
  task automatic tick();
    bit acc;
    acc = (req_valid === 1'b1) && (req_ready === 1'b1);
    @(posedge clk);
    #1;
    if (acc) begin
      if (m_idle) begin
        sb_words.delete();
        m_idx  = 0;
        m_idle = 1'b0;
      end
      sb_words.push_back(cur_offer);
      n_acc++;
      if (pend_offers.size() > 0) begin
        tw_t nx;
        nx = pend_offers.pop_front();
        offer_word(nx.digits, nx.dp);
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  // Follows one digit from the start of its blank phase to the next blank
  task automatic scan_digit(input string tag);
    int         waited;
    int         lit;
    bit         blank_ok, hold_ok, fd_ok, rdy_ok, do_pop, blk;
    tw_t        w;
    logic [3:0] es;
    logic [6:0] eg;
    logic       ed;
    waited = 0; blank_ok = 1'b1; rdy_ok = 1'b1;
    while (dig_sel === 4'b0000 && waited < 40) begin
      if (seg_out !== 7'h00 || dp_out !== 1'b0 || frame_done !== 1'b0) blank_ok = 1'b0;
      if (req_ready !== exp_ready()) rdy_ok = 1'b0;
      tick();
      waited++;
    end
    chk({tag, " blank_len"}, waited, TB_BLANK);
    chk({tag, " blank_zero"}, blank_ok, 1);
    chk({tag, " sb_nonempty"}, sb_words.size() != 0, 1);
    if (sb_words.size() == 0) return;
    w   = sb_words[0];
    blk = 1'b0;
`ifdef SEG7_BLINK_EN
    blk = blink_en && m_frame[TB_BLINK_SH];
`endif
    es = 4'b0001 << m_idx;
    eg = blk ? 7'h00 : hex7(w.digits[m_idx*4 +: 4]);
    ed = blk ? 1'b0 : w.dp[m_idx];
    chk({tag, " dig_sel"}, dig_sel, es);
    chk({tag, " seg_out"}, seg_out, eg);
    chk({tag, " dp_out"}, dp_out, ed);
    lit = 0; hold_ok = 1'b1; fd_ok = 1'b1; do_pop = 1'b0;
    while (dig_sel === es && lit < 40) begin
      if (seg_out !== eg || dp_out !== ed) hold_ok = 1'b0;
      if (frame_done !== (m_idx == 3 && lit == TB_DWELL - 1)) fd_ok = 1'b0;
      if (req_ready !== exp_ready()) rdy_ok = 1'b0;
      if (m_idx == 3 && lit == TB_DWELL - 1) do_pop = (sb_words.size() > 1);
      tick();
      lit++;
    end
    chk({tag, " dwell_len"}, lit, TB_DWELL);
    chk({tag, " hold"}, hold_ok, 1);
    chk({tag, " frame_done"}, fd_ok, 1);
    chk({tag, " req_ready"}, rdy_ok, 1);
    if (m_idx == 3) begin
      if (do_pop) void'(sb_words.pop_front());
      m_frame++;
    end
    m_idx = (m_idx + 1) % 4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; req_valid = 1'b0; req_digits = '0; req_dp = '0; blink_en = 1'b0;
    tick(); tick();
    ena = 1'b1;
    #1;
    chk("rst seg_out", seg_out, 0);
    chk("rst dig_sel", dig_sel, 0);
    chk("rst dp_out", dp_out, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst req_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst req_ready", req_ready, 1);
    tick(); tick();
    chk("idle dig_sel", dig_sel, 0);

    // Frame A: 4321 accepted in IDLE
    offer_word(16'h4321, 4'b0101);
    chk("A ready_idle", req_ready, 1);
    tick();
    chk("A acc_count", n_acc, 1);
    scan_digit("A0");
    // FFFF taken into the shadow, 89AB held until the shadow frees
    offer_word(16'hFFFF, 4'b1111);
    pend_offers.push_back('{digits: 16'h89AB, dp: 4'b0010});
    scan_digit("A1");
    chk("A shadow_acc", n_acc, 2);
    scan_digit("A2");
    scan_digit("A3");

    // Frame B: FFFF from the shadow; 89AB accepted once ready returns
    scan_digit("B0");
    chk("B second_acc", n_acc, 3);
    scan_digit("B1");
    scan_digit("B2");
    scan_digit("B3");

    // Frame C: 89AB, ena dropped during digit 2
    scan_digit("C0");
    scan_digit("C1");
    tick();
    chk("C2 on_sel", dig_sel, 4'b0100);
    chk("C2 on_seg", seg_out, hex7(4'h9));
    tick();
    ena = 1'b0;
    tick();
    m_idle = 1'b1;
    while (sb_words.size() > 1) void'(sb_words.pop_back());
    chk("ena_off dig_sel", dig_sel, 0);
    chk("ena_off seg_out", seg_out, 0);
    chk("ena_off dp_out", dp_out, 0);
    chk("ena_off frame_done", frame_done, 0);
    chk("ena_off req_ready", req_ready, 0);
    ena = 1'b1;
    #1;
    chk("ena_on req_ready", req_ready, 1);
    tick(); tick(); tick();
    chk("no_resume dig_sel", dig_sel, 0);

    // Frame D/E: re-accept restarts at digit 0
    offer_word(16'h5A6E, 4'b1000);
    tick();
    chk("D acc_count", n_acc, 4);
    scan_digit("D0");
    scan_digit("D1");
    scan_digit("D2");
    scan_digit("D3");
    scan_digit("E0");
    tick();
    chk("E1 on_sel", dig_sel, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst seg_out", seg_out, 0);
    chk("arst dig_sel", dig_sel, 0);
    chk("arst dp_out", dp_out, 0);
    chk("arst req_ready", req_ready, 0);
    sb_words.delete();
    m_idle = 1'b1; m_idx = 0; m_frame = 0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("arst_rel req_ready", req_ready, 1);
    tick();
    chk("arst_rel dig_sel", dig_sel, 0);

    // Final frames; with blinking built in, odd frames blank the segments
`ifdef SEG7_BLINK_EN
    blink_en = 1'b1;
`endif
    offer_word(16'h7E0B, 4'b0011);
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int d = 0; d < 4; d++) begin
        scan_digit($sformatf("F%0d_%0d", f, d));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg7_scan_ctrl
`default_nettype wire
